execute_pipeline_interlock: RTL
===============================

// Module: execute_pipeline_interlock
// PURPOSE
// Tracks in-flight register writes for the NUM_EXECUTE_STAGES execute stages between issue and
// register-file writeback. Compares the issuing instruction against every occupied stage with one
// data_hazard_detector instance per stage. Stalls issue on any RAW hazard and holds issue_ready
// low until the producer has retired. Sits between the trigger/issue stage and the execute pipeline.
// PARAMETERS
// NUM_EXECUTE_STAGES  2   tracked stages between issue and writeback; must be >= 1 (elab error if 0)
// STALL_COUNT_WIDTH   16  width of the saturating hazard-stall counter
// PORTS
// clock         in   1                         rising-edge clock
// reset         in   1                         synchronous, active-high reset
// issue_valid   in   1                         issue stage presents a triggered instruction
// issue_st      in   TIA_ST_WIDTH              source types of issuing instruction
// issue_si      in   TIA_SI_WIDTH              source indices of issuing instruction
// issue_dt      in   TIA_DT_WIDTH              destination type of issuing instruction
// issue_di      in   TIA_DI_WIDTH              destination index of issuing instruction
// halt          in   1                         global pipeline freeze (e.g. channel backpressure)
// flush         in   1                         squash all in-flight entries
// issue_ready   out  1                         instruction accepted into stage 0 this cycle
// hazard        out  1                         RAW hazard against any valid stage
// stage_valid   out  NUM_EXECUTE_STAGES        per-stage occupancy; bit 0 = youngest
// stage_dt      out  NUM_EXECUTE_STAGES*DT     per-stage destination type, stage k at slice k
// stage_di      out  NUM_EXECUTE_STAGES*DI     per-stage destination index, stage k at slice k
// stall_count   out  STALL_COUNT_WIDTH         saturating count of hazard-stall cycles
// BEHAVIOUR
// - Per stage k: registers valid_k, dt_k, di_k. Reset: all valid=0, dt=0, di=0, stall_count=0.
// - hazard (comb) = issue_valid & OR_k(valid_k & detector(issue_st, issue_si, dt_k, di_k)).
//   An invalid stage never contributes, regardless of its stale dt/di.
// - issue_ready (comb) = issue_valid & ~hazard & ~halt & ~flush & ~reset.
// - Stage update priority, highest first:
//   1. reset: clear everything.
//   2. flush: all valid_k <= 0 next cycle. Flush overrides halt. An issue presented in the same
//      cycle is not accepted.
//   3. halt: all stage registers hold.
//   4. Otherwise shift: stage k <= stage k-1. Stage 0 <= {1, issue_dt, issue_di} if issue_ready,
//      else a bubble (valid=0, dt/di hold).
// - Entries leaving stage N-1 retire; the register-file write happens on that edge.
// - A dependent instruction is accepted the cycle after its producer leaves stage N-1.
//   Back-to-back RAW therefore costs exactly NUM_EXECUTE_STAGES stall cycles (no halts).
// - A hazard exists only for source type TIA_SOURCE_TYPE_REGISTER against destination type
//   TIA_DESTINATION_TYPE_REGISTER with equal index. Channel, immediate and predicate operands
//   never stall.
// - An instruction whose own dest matches its own source does not self-hazard; only older
//   instructions in the stages are checked.
// - stall_count increments on cycles with issue_valid & hazard & ~halt & ~flush & ~reset.
//   It saturates at all-ones, never wraps, and is cleared only by reset.
// - Reset asserted mid-operation drops all in-flight entries. The first cycle after reset
//   deasserts sees no hazard.
// - Outputs stage_* are registered; hazard and issue_ready are combinational from inputs and state.
// TESTING
// 1. N=2: c0 issue dt=REG di=3 (accepted); c1 issue src0=REG r3 -> issue_ready=0 on c1 and c2,
//    =1 on c3; stall_count=2.
// 2. c0 write r3, c1 read r4 and r5 -> no stall; issue_ready=1 on c1; stage_valid=2'b11 after c1.
// 3. Case 1 with halt high on c1..c3 -> stage_* frozen, issue_ready=0, stall_count frozen during
//    halt; dependent accepted 2 cycles after halt drops; final stall_count=2.
// 4. Producer in stage 0, flush on c1 with dependent valid -> not accepted c1; stage_valid=0 on c2;
//    dependent accepted c2 with no hazard.
// 5. src0 channel-type index 3 vs in-flight REG r3 -> no stall. Producer with non-register dest
//    di=3 vs REG r3 reader -> no stall.
// 6. Force a persistent hazard for 2^16+4 cycles -> stall_count holds 16'hFFFF. Assert reset
//    mid-stall -> next cycle stall_count=0, stage_valid=0, issue_ready=1.

Source files
------------

// File: rtl/execute_pipeline_interlock.sv
// Execute-stage RAW interlock: tracks in-flight register writes between issue
// and writeback, stalls issue while an older instruction still owns a source
// register, and keeps a saturating count of hazard-stall cycles.

// Compares one tracked destination against every source operand of the
// issuing instruction. Only register-to-register matches are hazards.
module data_hazard_detector #(
  parameter int NUM_SRCS          = 2,
  parameter int SOURCE_TYPE_WIDTH = 2,
  parameter int DT_WIDTH          = 2,
  parameter int INDEX_WIDTH       = 3,
  parameter logic [SOURCE_TYPE_WIDTH-1:0] SOURCE_TYPE_REGISTER      = 2'd3,
  parameter logic [DT_WIDTH-1:0]          DESTINATION_TYPE_REGISTER = 2'd2
) (
  input  logic [NUM_SRCS*SOURCE_TYPE_WIDTH-1:0] st,
  input  logic [NUM_SRCS*INDEX_WIDTH-1:0]       si,
  input  logic [DT_WIDTH-1:0]                   dt,
  input  logic [INDEX_WIDTH-1:0]                di,
  output logic                                  hit
);

  // Any register source reading the tracked register destination is a hit.
  always_comb begin
    hit = 1'b0;
    for (int j = 0; j < NUM_SRCS; j++) begin
      if ((st[j*SOURCE_TYPE_WIDTH +: SOURCE_TYPE_WIDTH] == SOURCE_TYPE_REGISTER) &&
          (dt == DESTINATION_TYPE_REGISTER) &&
          (si[j*INDEX_WIDTH +: INDEX_WIDTH] == di)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

module execute_pipeline_interlock #(
  parameter int NUM_EXECUTE_STAGES    = 2,
  parameter int STALL_COUNT_WIDTH     = 16,
  parameter int TIA_NUM_SRCS          = 2,
  parameter int TIA_SOURCE_TYPE_WIDTH = 2,
  parameter int TIA_DT_WIDTH          = 2,
  parameter int TIA_DI_WIDTH          = 3,
  parameter int TIA_ST_WIDTH          = TIA_NUM_SRCS * TIA_SOURCE_TYPE_WIDTH,
  parameter int TIA_SI_WIDTH          = TIA_NUM_SRCS * TIA_DI_WIDTH,
  parameter logic [TIA_SOURCE_TYPE_WIDTH-1:0] TIA_SOURCE_TYPE_REGISTER      = 2'd3,
  parameter logic [TIA_DT_WIDTH-1:0]          TIA_DESTINATION_TYPE_REGISTER = 2'd2
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       issue_valid,
  input  logic [TIA_ST_WIDTH-1:0]                    issue_st,
  input  logic [TIA_SI_WIDTH-1:0]                    issue_si,
  input  logic [TIA_DT_WIDTH-1:0]                    issue_dt,
  input  logic [TIA_DI_WIDTH-1:0]                    issue_di,
  input  logic                                       halt,
  input  logic                                       flush,
  output logic                                       issue_ready,
  output logic                                       hazard,
  output logic [NUM_EXECUTE_STAGES-1:0]              stage_valid,
  output logic [NUM_EXECUTE_STAGES*TIA_DT_WIDTH-1:0] stage_dt,
  output logic [NUM_EXECUTE_STAGES*TIA_DI_WIDTH-1:0] stage_di,
  output logic [STALL_COUNT_WIDTH-1:0]               stall_count
);

  if (NUM_EXECUTE_STAGES < 1) begin : g_bad_stage_count
    $error("execute_pipeline_interlock: NUM_EXECUTE_STAGES must be >= 1");
  end

  logic [NUM_EXECUTE_STAGES-1:0]                   valid_q;
  logic [NUM_EXECUTE_STAGES-1:0][TIA_DT_WIDTH-1:0] dt_q;
  logic [NUM_EXECUTE_STAGES-1:0][TIA_DI_WIDTH-1:0] di_q;
  logic [NUM_EXECUTE_STAGES-1:0]                   det_hit;
  logic [STALL_COUNT_WIDTH-1:0]                    stall_count_q;
  logic                                            stall_event;

  // One detector per tracked stage; stale dt/di of an empty stage are masked below.
  for (genvar k = 0; k < NUM_EXECUTE_STAGES; k++) begin : g_det
    data_hazard_detector #(
      .NUM_SRCS                  (TIA_NUM_SRCS),
      .SOURCE_TYPE_WIDTH         (TIA_SOURCE_TYPE_WIDTH),
      .DT_WIDTH                  (TIA_DT_WIDTH),
      .INDEX_WIDTH               (TIA_DI_WIDTH),
      .SOURCE_TYPE_REGISTER      (TIA_SOURCE_TYPE_REGISTER),
      .DESTINATION_TYPE_REGISTER (TIA_DESTINATION_TYPE_REGISTER)
    ) u_det (
      .st  (issue_st),
      .si  (issue_si),
      .dt  (dt_q[k]),
      .di  (di_q[k]),
      .hit (det_hit[k])
    );
  end

  // Hazard and acceptance are combinational so issue sees them in the same cycle.
  always_comb begin
    hazard      = issue_valid & |(valid_q & det_hit);
    issue_ready = issue_valid & ~hazard & ~halt & ~flush & ~reset;
    stall_event = issue_valid & hazard & ~halt & ~flush;
  end

  // Stage shift register: reset > flush > halt > advance (bubble keeps old dt/di).
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      dt_q    <= '0;
      di_q    <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (!halt) begin
      for (int k = NUM_EXECUTE_STAGES - 1; k >= 1; k--) begin
        valid_q[k] <= valid_q[k-1];
        dt_q[k]    <= dt_q[k-1];
        di_q[k]    <= di_q[k-1];
      end
      valid_q[0] <= issue_ready;
      if (issue_ready) begin
        dt_q[0] <= issue_dt;
        di_q[0] <= issue_di;
      end
    end
  end

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_q <= '0;
    end else if (stall_event && (stall_count_q != {STALL_COUNT_WIDTH{1'b1}})) begin
      stall_count_q <= stall_count_q + STALL_COUNT_WIDTH'(1);
    end
  end

  assign stage_valid = valid_q;
  assign stage_dt    = dt_q;
  assign stage_di    = di_q;
  assign stall_count = stall_count_q;

endmodule
